// File: rtl/fir_pkg.sv
// fir_pkg: shared types and helpers for the sequential FIR (fir_mac_seq).
//   fir_state_t  : controller states (IDLE, MAC, SAVE)
//   acc_width()  : accumulator width that cannot overflow over NTAPS products
//   round_sat()  : round-half-up, arithmetic shift by frac, clamp to dw bits
//   DEF_*        : default parameter values
package fir_pkg;

  localparam int DEF_NTAPS = 16;
  localparam int DEF_DW    = 16;
  localparam int DEF_CW    = 16;
  localparam int DEF_FRAC  = 15;

  // Width of the generic round/saturate datapath; accumulators up to 63 bits
  // are sign-extended into it without loss.
  localparam int RS_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SAVE
  } fir_state_t;

  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  // Adds half an LSB of the result before the arithmetic shift so ties round
  // towards +infinity, then clamps to the signed dw-bit range.
  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     frac,
    input int                     dw
  );
    logic signed [RS_W-1:0] half;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    logic signed [RS_W-1:0] r;
    half = 64'sd1 <<< (frac - 1);
    hi   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (dw - 1));
    r    = (acc + half) >>> frac;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed DW x CW multiply-accumulate with a round/saturate output stage.
//   ck, rst  : clock, asynchronous active-high reset
//   clr      : zero the accumulator (start of a new dot product)
//   en       : accumulate a*b
//   save     : register round_sat(acc) into res and pulse res_vld
//   a, b     : signed sample and coefficient operands
//   res      : signed DW-bit result, held between saves
//   res_vld  : one-cycle pulse, res is new in that cycle
module fir_mac
  import fir_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int CW   = DEF_CW,
  parameter int FRAC = DEF_FRAC,
  parameter int ACCW = acc_width(DEF_DW, DEF_CW, DEF_NTAPS)
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 save,
  input  logic signed [DW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [DW-1:0] res,
  output logic                 res_vld
);

  localparam int PW = DW + CW;

  logic signed [PW-1:0]   prod_p0;
  logic signed [ACCW-1:0] acc_p1;
  logic signed [DW-1:0]   res_p2;
  logic                   vld_p2;

  // ---- p0: full-precision product (combinational) ----
  assign prod_p0 = PW'(a) * PW'(b);

  // ---- p1: accumulator ----
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
    end else if (clr) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= acc_p1 + ACCW'(prod_p0);
    end
  end

  // ---- p2: rounded, saturated result register ----
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      res_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= save;
      if (save) begin
        res_p2 <= DW'(round_sat(RS_W'(acc_p1), FRAC, DW));
      end
    end
  end

  assign res     = res_p2;
  assign res_vld = vld_p2;

endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: runtime-programmable sequential FIR, one multiplier shared over
// NTAPS taps. One sample is accepted per handshake while idle; the result
// appears NTAPS+1 cycles after the accept edge with a one-cycle valid pulse.
//   ck, rst       : clock, asynchronous active-high reset
//   in            : signed DW-bit sample
//   input_ready   : sample valid, taken only when busy=0
//   coef_we       : coefficient write strobe (taken only when busy=0)
//   coef_addr     : coefficient index; indices >= NTAPS are ignored
//   coef_data     : signed CW-bit coefficient
//   out           : signed DW-bit filtered result, held between updates
//   output_ready  : one-cycle pulse, out is new in that cycle
//   busy          : high while a computation is in flight
//   overrun       : sticky, set when a sample or coefficient write is dropped
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic signed [DW-1:0]         in,
  input  logic                         input_ready,
  input  logic                         coef_we,
  input  logic [$clog2(NTAPS)-1:0]     coef_addr,
  input  logic signed [CW-1:0]         coef_data,
  output logic signed [DW-1:0]         out,
  output logic                         output_ready,
  output logic                         busy,
  output logic                         overrun
);

  localparam int             AW   = $clog2(NTAPS);
  localparam int             ACCW = acc_width(DW, CW, NTAPS);
  localparam logic [AW-1:0]  LAST = AW'(NTAPS - 1);

  fir_state_t          state;
  logic [AW-1:0]       addr;
  logic signed [DW-1:0] samples [NTAPS];
  logic signed [CW-1:0] coefs   [NTAPS];
  logic                accept;

  assign accept = (state == IDLE) && input_ready;
  assign busy   = (state != IDLE);

  // ---- p0: controller, history shift register, coefficient RAM ----
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        samples[i] <= '0;
        coefs[i]   <= '0;
      end
    end else begin
      // Anything presented while a computation runs is dropped.
      if ((state != IDLE) && (input_ready || coef_we)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          // A write in the accept cycle lands before the first MAC edge, so
          // the new coefficient takes part in this computation.
          if (coef_we && (32'(coef_addr) < NTAPS)) begin
            coefs[coef_addr] <= coef_data;
          end
          if (input_ready) begin
            for (int i = NTAPS - 1; i > 0; i--) begin
              samples[i] <= samples[i-1];
            end
            samples[0] <= in;
            addr       <= '0;
            state      <= MAC;
          end
        end
        MAC: begin
          // The address parks on the last tap rather than wrapping.
          if (addr == LAST) begin
            state <= SAVE;
          end else begin
            addr <= addr + AW'(1);
          end
        end
        SAVE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---- p1/p2: shared MAC and output stage ----
  fir_mac #(
    .DW  (DW),
    .CW  (CW),
    .FRAC(FRAC),
    .ACCW(ACCW)
  ) u_mac (
    .ck     (ck),
    .rst    (rst),
    .clr    (accept),
    .en     (state == MAC),
    .save   (state == SAVE),
    .a      (samples[addr]),
    .b      (coefs[addr]),
    .res    (out),
    .res_vld(output_ready)
  );

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: a cycle-level behavioural model (dot
// product over a sample history, accept/finish times from cycle arithmetic)
// is compared against the DUT every cycle, plus hand-computed results.
module tb_fir_mac_seq;

  localparam int NTAPS = 16;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int FRAC  = 15;
  localparam int AW    = 4;

  logic                 ck = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] in_s = '0;
  logic                 input_ready = 1'b0;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic signed [DW-1:0] out;
  logic                 output_ready;
  logic                 busy;
  logic                 overrun;

  int n_tests = 0;
  int n_fail  = 0;

  fir_mac_seq #(
    .NTAPS(NTAPS),
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC)
  ) dut (
    .ck          (ck),
    .rst         (rst),
    .in          (in_s),
    .input_ready (input_ready),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .out         (out),
    .output_ready(output_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 ck = ~ck;

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_hist [NTAPS];
  longint m_coef [NTAPS];
  longint m_out = 0;
  longint m_res = 0;
  bit     m_rdy = 1'b0;
  bit     m_pend = 1'b0;
  bit     m_ovr = 1'b0;
  longint k = 0;
  longint acc_edge = 0;

  // Exact dot product, then floor((acc + 2^(FRAC-1)) / 2^FRAC), then clamp.
  function automatic longint ref_result();
    longint acc, num, d, q, hi, lo;
    acc = 0;
    for (int i = 0; i < NTAPS; i++) acc += m_hist[i] * m_coef[i];
    num = acc + (longint'(1) << (FRAC - 1));
    d   = longint'(1) << FRAC;
    q   = num / d;
    if ((num % d != 0) && (num < 0)) q -= 1;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      m_hist[i] = 0;
      m_coef[i] = 0;
    end
    m_out  = 0;
    m_rdy  = 1'b0;
    m_pend = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // One rising edge: busy from accept edge n until the result edge n+NTAPS+1.
  task automatic model_edge();
    k++;
    m_rdy = 1'b0;
    if (m_pend) begin
      if (input_ready || coef_we) m_ovr = 1'b1;
      if (k == acc_edge + NTAPS + 1) begin
        m_out  = m_res;
        m_rdy  = 1'b1;
        m_pend = 1'b0;
      end
    end else begin
      if (coef_we && (int'(coef_addr) < NTAPS)) m_coef[coef_addr] = longint'(coef_data);
      if (input_ready) begin
        for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = longint'(in_s);
        m_res     = ref_result();
        m_pend    = 1'b1;
        acc_edge  = k;
      end
    end
  endtask

  always @(posedge ck or posedge rst) begin
    if (rst) model_reset();
    else     model_edge();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge ck) begin
    check("out", out, m_out);
    check("output_ready", output_ready, longint'(m_rdy));
    check("busy", busy, longint'(m_pend));
    check("overrun", overrun, longint'(m_ovr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(d);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic accept(input int v);
    input_ready = 1'b1;
    in_s        = DW'(v);
    tick();
    input_ready = 1'b0;
  endtask

  // Waits (bounded) for output_ready; optionally checks value and latency
  // counted in edges since the accept edge.
  task automatic expect_result(input string name, input longint exp, input bit chk_val,
                               input bit chk_lat);
    int cnt;
    bit got;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      tick();
      cnt++;
      if (output_ready === 1'b1) got = 1'b1;
    end
    check({name, "_seen"}, got, 1);
    if (got && chk_val) check(name, out, exp);
    if (got && chk_lat) check({name, "_lat"}, cnt, NTAPS + 1);
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0:       return int'($signed(16'($urandom)));
      1:       return int'($urandom_range(0, 200)) - 100;
      2:       return ($urandom_range(0, 1) == 0) ? 32767 : -32768;
      default: return 0;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int pulses;
    #1;
    do_reset();
    check("rst_out", out, 0);
    check("rst_ready", output_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // Single tap at 0.5
    write_coef(0, 16384);
    accept(1000);
    expect_result("half_gain", 500, 1'b1, 1'b1);

    // Impulse response
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 100 * (i + 1));
    accept(32767);
    expect_result("imp_0", 100, 1'b1, 1'b1);
    for (int j = 1; j < NTAPS; j++) begin
      accept(0);
      expect_result("imp_n", 100 * (j + 1), 1'b1, 1'b1);
    end
    accept(0);
    expect_result("imp_tail", 0, 1'b1, 1'b1);

    // Saturation both ways
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 32767);
    for (int j = 0; j < NTAPS; j++) begin
      accept(32767);
      expect_result("sat_pos", 32767, j == NTAPS - 1, 1'b0);
    end
    for (int j = 0; j < NTAPS; j++) begin
      accept(-32768);
      expect_result("sat_neg", -32768, j == NTAPS - 1, 1'b0);
    end

    // Rounding at the half-LSB boundary
    do_reset();
    write_coef(0, 1);
    accept(16384);
    expect_result("round_half", 1, 1'b1, 1'b1);
    accept(16383);
    expect_result("round_below", 0, 1'b1, 1'b1);

    // Overrun: sample and coefficient write during MAC are dropped
    do_reset();
    write_coef(0, 16384);
    write_coef(1, 16384);
    accept(2000);
    tick();
    tick();
    input_ready = 1'b1;
    in_s        = 16'sd5000;
    coef_we     = 1'b1;
    coef_addr   = 4'd1;
    coef_data   = '0;
    tick();
    input_ready = 1'b0;
    coef_we     = 1'b0;
    check("ovr_set", overrun, 1);
    expect_result("ovr_res", 1000, 1'b1, 1'b0);
    accept(4000);
    expect_result("ovr_after", 3000, 1'b1, 1'b1);
    check("ovr_sticky", overrun, 1);

    // Back-to-back accept in the output_ready cycle
    do_reset();
    write_coef(0, 16384);
    accept(1000);
    expect_result("b2b_first", 500, 1'b1, 1'b1);
    accept(3000);
    check("b2b_no_ovr", overrun, 0);
    expect_result("b2b_second", 1500, 1'b1, 1'b1);

    // Reset in the middle of MAC
    do_reset();
    write_coef(0, 16384);
    write_coef(2, 16384);
    accept(1000);
    accept(1000);
    // second accept is the first MAC edge; six more reach address 7
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out", out, 0);
    check("midrst_ready", output_ready, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (output_ready !== 1'b0) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    write_coef(0, 16384);
    write_coef(2, 16384);
    accept(600);
    expect_result("midrst_after", 300, 1'b1, 1'b1);

    // Randomized traffic, including drops while busy
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      input_ready = ($urandom_range(0, 3) == 0);
      in_s        = DW'(rnd_val());
      coef_we     = ($urandom_range(0, 7) == 0);
      coef_addr   = AW'($urandom_range(0, NTAPS - 1));
      coef_data   = CW'(rnd_val());
      tick();
    end
    input_ready = 1'b0;
    coef_we     = 1'b0;
    repeat (NTAPS + 4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Parametrised, runtime-programmable sequential FIR filter. It is the next generation of the fixed 16-tap/16-bit FIR. It accepts one sample per handshake and computes the dot product over NTAPS taps using a single time-multiplexed multiplier. It then emits a rounded, saturated result with a one-cycle valid pulse. It sits between the sample source (ADC/decimator) and downstream DSP, and has a coefficient write port for host configuration.

## Interface
- NTAPS, 16: number of taps, ≥2.
- DW, 16: signed sample and output width.
- CW, 16: signed coefficient width.
- FRAC, 15: coefficient fractional bits (result = acc >>> FRAC), 1 ≤ FRAC < CW+DW.
- ck  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  DW  signed input sample.
- input_ready  in  1  sample valid; accepted only when busy=0.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(NTAPS)  coefficient index.
- coef_data  in  CW  signed coefficient value.
- out  out  DW  signed filtered result, held between updates.
- output_ready  out  1  one-cycle pulse; out is new in that cycle.
- busy  out  1  high whenever state ≠ IDLE.
- overrun  out  1  sticky; set when a sample or coefficient write is dropped.

## Operation
- States: IDLE, MAC, SAVE.
- IDLE, input_ready=1:
  - shift history (samples[i] <= samples[i-1], samples[0] <= in);
  - clear accumulator; address <= 0; go to MAC.
- MAC:
  - acc <= acc + samples[address]*coef[address]; address increments.
  - On the edge where address = NTAPS-1, go to SAVE. The address never exceeds NTAPS-1; no wrap beyond it.
- SAVE: out <= sat(round(acc)); output_ready <= 1 for one cycle; go to IDLE.
- Arithmetic:
  - product width DW+CW;
  - accumulator width ACCW = DW+CW+clog2(NTAPS), so it never overflows;
  - round = (acc + 2^(FRAC-1)) >>> FRAC (round half up);
  - saturate to [-2^(DW-1), 2^(DW-1)-1].
- Coefficients:
  - A write while busy=0 updates coef[coef_addr] at the edge.
  - A write while busy=1 is ignored and sets overrun.
  - If IDLE sees input_ready and coef_we in the same cycle, both take effect. The new coefficient is used by this computation.
  - coef_addr ≥ NTAPS is ignored silently.
- input_ready while busy=1: sample dropped, history unchanged, overrun set.
- Reset:
  - state=IDLE, out=0, output_ready=0, overrun=0;
  - history, coefficients, accumulator and address all 0.
  - Asserting reset mid-MAC aborts the computation immediately. No output_ready is produced for the aborted sample.

## Timing
- Accept edge E0. MAC edges E1..E_NTAPS. SAVE edge E_NTAPS+1 registers out and output_ready.
- Latency from accept edge to output_ready: NTAPS+1 cycles. Throughput: one sample per NTAPS+2 cycles. The next sample can be accepted in the cycle output_ready is high, because busy=0 then.
- busy rises the cycle after acceptance and falls the cycle output_ready rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package fir_pkg:
  - state enum (fir_state_t: IDLE, MAC, SAVE);
  - function acc_width(DW,CW,NTAPS);
  - saturation/round helper function;
  - default parameter constants.
- Sub-module fir_mac: a DW×CW multiply-accumulate with clear, enable, and a round/saturate output stage. The top level holds the history shift register, coefficient RAM, address counter and controller.

## Test plan
- NTAPS=16, DW=CW=16, FRAC=15.
  - coef[0]=16384, others 0; input 1000 → out=500, output_ready exactly 17 cycles after accept.
- Impulse response:
  - coef[k]=100*(k+1); feed 32767 then 15 zeros → out sequence 100, 200, …, 1600; then a further zero input → 0.
- Saturation:
  - all coefs 32767; 16 samples of 32767 → out 32767;
  - 16 samples of -32768 → out -32768.
- Rounding:
  - coef[0]=1, FRAC=15; input 16384 → out 1 (half rounds up);
  - input 16383 → out 0.
- Overrun:
  - input_ready pulsed and coef_we issued during MAC → overrun=1, history and coefficients unchanged, current result still correct;
  - back-to-back accept in the output_ready cycle → no overrun.
- Reset mid-MAC:
  - assert rst at address 7 → busy=0, out=0, no output_ready pulse;
  - after reprogramming, the next result matches the zero-history model.
